maxpool_2x2_stream: RTL
=======================

Name: maxpool_2x2_stream

Overview:
- Downstream neighbour of the requantization stage. Consumes its signed int8 pixel stream, one channel plane in raster order, one pixel per valid cycle.
- Performs 2x2 max pooling with stride 2 and emits one signed int8 result per pooled window.
- Keeps the pairwise maxima of even rows in a half-width line buffer, so the plane passes through without frame storage.
- No backpressure: the upstream stage has none, so this block always accepts.

Parameters:
- MAX_WIDTH, 416, largest supported plane width in pixels.
- DIM_W, 9, bit width of the width/height/column/row counters; must satisfy 2**DIM_W >= MAX_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; latches img_width/img_height and arms a new plane.
- img_width  input  DIM_W  plane width in pixels; legal range 2..MAX_WIDTH.
- img_height  input  DIM_W  plane height in pixels; legal minimum 2.
- data_in  input  8  signed int8 pixel.
- valid_in  input  1  data_in valid this cycle.
- data_out  output  8  signed pooled maximum.
- valid_out  output  1  data_out valid.
- busy  output  1  high from the cycle after start until the plane's last pixel is accepted.
- frame_done  output  1  one-cycle pulse after the last pixel of the plane is accepted.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Line buffer contents are don't-care.
- States and transitions:
  - IDLE: valid_in is ignored. start -> EVEN_ROW.
  - EVEN_ROW / ODD_ROW: row/col counters advance on valid_in only.
  - Row change: when col == W-1 the row ends; col returns to 0, row increments, and state toggles EVEN_ROW <-> ODD_ROW.
  - Plane end: the last accepted pixel (row == H-1, col == W-1) -> IDLE, frame_done=1 next cycle, busy=0 next cycle.
- Geometry: W and H are latched at start. Pooled output is floor(W/2) x floor(H/2).
  - Odd W: the final column's pixel is consumed but not used.
  - Odd H: the final row is consumed but produces no output.
- EVEN_ROW datapath:
  - Even col: hold the pixel.
  - Odd col: write max(held, pixel) to line buffer address col>>1.
- ODD_ROW datapath:
  - Even col: hold the pixel and issue a read of address col>>1 (registered read, 1-cycle latency).
  - Odd col: compute max(held, pixel, buffer data) and register it to data_out. valid_out=1 exactly one cycle after the pixel is accepted.
- All comparisons are signed two's complement; -128 is the identity.
- Gaps in valid_in are allowed anywhere. Held values and pending read data must persist across gaps; the read data register holds until consumed.
- start while busy: abandons the current plane. Counters clear, new geometry latches, state -> EVEN_ROW. No frame_done for the abandoned plane. A valid_in in the same cycle as start is ignored.
- valid_out outside ODD_ROW odd-column accepts is always 0.
- rst mid-plane: immediate return to reset values. No output pulse is generated.

Optional Feature:
- Macro MAXPOOL_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit), latched at start.
  - With bypass latched high, each accepted pixel appears on data_out with valid_out one cycle later; the line buffer is unused.
  - Counters and frame_done behave unchanged.
- When not defined: no bypass port; pooling is always active.

Decomposition:
- Shared package (e.g. yolo_pkg) holds:
  - typedef pixel_t (logic signed [7:0]);
  - constants PIX_MIN = -128 and MAX_WIDTH_DEFAULT = 416;
  - enum pool_state_t {IDLE, EVEN_ROW, ODD_ROW}.
- One sub-module, pool_line_buffer: simple dual-port RAM, depth MAX_WIDTH/2, 8-bit, one write port and one registered read port on clk. It must infer block or distributed RAM.

Test Plan:
- 4x4 plane, rows [1,2,3,4], [5,6,7,8], [-1,-2,-3,-4], [9,0,0,10], contiguous valid -> outputs 6, 8, 9, 10 with exactly 4 valid_out pulses. frame_done fires one cycle after the 16th pixel.
- All-negative 2x2 plane {-128,-5,-7,-128} -> single output -5 (signed compare check).
- 5x3 plane, values = raster index -> outputs 6, 8 only. Column 4 and row 2 are ignored; frame_done still fires after 15 accepts.
- 4x2 plane with a random 0-3 cycle valid_in gap after every pixel -> same outputs as the gap-free run. Each valid_out occurs one cycle after the corresponding odd-row, odd-column accept.
- start asserted mid-plane after 6 pixels of 4x4, then a fresh 2x2 plane {3,1,2,0} -> single output 3; no frame_done for the aborted plane.
- With MAXPOOL_BYPASS_EN and bypass=1, 2x2 plane {7,-3,4,1} -> outputs 7, -3, 4, 1 each one cycle after input; then frame_done.

Source files
------------

// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared types and constants for the 2x2 max-pooling stream stage.
package maxpool_2x2_stream_pkg;

    typedef logic signed [7:0] pixel_t;

    // Smallest int8 value; the identity element of a signed max.
    localparam pixel_t PIX_MIN           = pixel_t'(-128);
    localparam int     MAX_WIDTH_DEFAULT = 416;

    typedef enum logic [1:0] {
        IDLE,
        EVEN_ROW,
        ODD_ROW
    } pool_state_t;

    // Signed maximum of two pixels.
    function automatic pixel_t pix_max(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_2x2_stream_line_buffer.sv
// pool_line_buffer: simple dual-port RAM holding the pairwise maxima of
// an even row. One write port, one registered read port, both on clk.
module pool_line_buffer #(
    parameter int DEPTH  = 208,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    // Write port plus registered read; rdata holds its value until the next read.
    // NOTE: no reset on the array or its read register -- a reset would stop the
    // tools from mapping this onto RAM, and stale contents are never consumed
    // before being rewritten. Non-blocking assignments keep every register
    // updating from pre-edge values, so simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream: 2x2 / stride-2 signed int8 max pooling over a raster
// stream, one channel plane at a time. Pairwise maxima of each even row are
// parked in a half-width line buffer and combined with the following odd row.
// Optional feature: define MAXPOOL_BYPASS_EN to add a 'bypass' input, latched
// at start, that passes every accepted pixel straight through.
module maxpool_2x2_stream
    import maxpool_2x2_stream_pkg::*;
#(
    parameter int MAX_WIDTH = MAX_WIDTH_DEFAULT,
    parameter int DIM_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
`ifdef MAXPOOL_BYPASS_EN
    input  logic             bypass,
`endif
    input  logic [7:0]       data_in,
    input  logic             valid_in,
    output logic [7:0]       data_out,
    output logic             valid_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int LB_DEPTH  = MAX_WIDTH / 2;
    localparam int LB_ADDR_W = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    pool_state_t          state_q, state_d;
    logic [DIM_W-1:0]     col_q, row_q, width_q, height_q;
    pixel_t               held_q;
    logic                 bypass_q;

    logic                 accept, last_col, last_row, odd_col;
    logic                 lb_we, lb_re, pool_fire, pass_fire;
    logic [LB_ADDR_W-1:0] lb_addr;
    pixel_t               pair_max, pool_max, lb_rdata;
    logic [7:0]           lb_rdata_raw;

    // A start always wins over a same-cycle pixel; IDLE ignores pixels.
    assign accept   = valid_in && !start && (state_q != IDLE);
    assign last_col = (col_q == width_q - DIM_W'(1));
    assign last_row = (row_q == height_q - DIM_W'(1));
    assign odd_col  = col_q[0];
    assign busy     = (state_q != IDLE);

    assign lb_addr  = LB_ADDR_W'(col_q >> 1);
    assign lb_rdata = pixel_t'(lb_rdata_raw);
    assign pair_max = pix_max(held_q, pixel_t'(data_in));
    assign pool_max = pix_max(pair_max, lb_rdata);

`ifdef MAXPOOL_BYPASS_EN
    // Bypass mode is fixed for the whole plane.
    always_ff @(posedge clk) begin
        if (rst) begin
            bypass_q <= 1'b0;
        end else if (start) begin
            bypass_q <= bypass;
        end
    end
`else
    assign bypass_q = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start (re)arms a plane; row ends toggle parity; last pixel ends it.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = EVEN_ROW;
        end else if (accept && last_col) begin
            if (last_row) begin
                state_d = IDLE;
            end else if (state_q == EVEN_ROW) begin
                state_d = ODD_ROW;
            end else begin
                state_d = EVEN_ROW;
            end
        end
    end

    // Datapath strobes decoded from state, column parity and the accept.
    // NOTE: every signal gets a default before the branches, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        lb_we     = 1'b0;
        lb_re     = 1'b0;
        pool_fire = 1'b0;
        pass_fire = 1'b0;
        if (accept) begin
            if (bypass_q) begin
                pass_fire = 1'b1;
            end else if (state_q == EVEN_ROW) begin
                lb_we = odd_col;
            end else if (state_q == ODD_ROW) begin
                lb_re     = !odd_col;
                pool_fire = odd_col;
            end
        end
    end

    // Geometry latch and raster position counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
        end else if (start) begin
            col_q    <= '0;
            row_q    <= '0;
            width_q  <= img_width;
            height_q <= img_height;
        end else if (accept) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row_q + DIM_W'(1);
            end else begin
                col_q <= col_q + DIM_W'(1);
            end
        end
    end

    // Even-column pixel is held until its odd-column partner arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= PIX_MIN;
        end else if (accept && !odd_col) begin
            held_q <= pixel_t'(data_in);
        end
    end

    // Registered outputs: pooled result or bypassed pixel, and the plane-end pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= pool_fire || pass_fire;
            frame_done <= accept && last_col && last_row;
            if (pool_fire) begin
                data_out <= pool_max;
            end else if (pass_fire) begin
                data_out <= data_in;
            end
        end
    end

    pool_line_buffer #(
        .DEPTH  (LB_DEPTH),
        .ADDR_W (LB_ADDR_W)
    ) u_line_buffer (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pair_max),
        .re    (lb_re),
        .raddr (lb_addr),
        .rdata (lb_rdata_raw)
    );

endmodule
